// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the pipeline front end
// Purpose: common word type and the fetch-stage state encoding.
// Contents: word_t (32-bit instruction/data word), fetch_state_t (FETCH, BUFFERED, HALTED).
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    HALTED   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and hold controls
// Purpose: holds the fetched instruction and its PC+4 for the decode stage.
// Ports: CLK, nRST (async, active-low); load/bubble controls (bubble wins, neither = hold);
//        instr_in/pc4_in data in; valid/instr/pc4 register contents out.
module if_id_reg
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_INSTR = 32'h00000000,
  parameter int    PC_WIDTH  = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                load,
  input  logic                bubble,
  input  word_t               instr_in,
  input  logic [PC_WIDTH-1:0] pc4_in,
  output logic                valid,
  output word_t               instr,
  output logic [PC_WIDTH-1:0] pc4
);

  // A bubble leaves the register in exactly its reset image so decode
  // cannot tell a squashed slot from a post-reset slot.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc4   <= pc4_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: FSM, PC enable and IF/ID register
// Purpose: issues instruction reads at pc_in, fills IF/ID, and honours halt/flush/stall.
// Ports: CLK, nRST (async, active-low); pc_in, pc_plus_4_in from the PC;
//        iREN/iaddr/ihit/iload to instruction memory; stall, flush, halt_in controls;
//        pc_en to the PC; ifid_valid/ifid_instr/ifid_pc4 IF/ID contents.
// Config: define FETCH_SKID_BUFFER_EN to add a one-entry skid buffer that keeps a word
//         arriving during a stall instead of re-fetching it.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_INSTR = 32'h00000000,
  parameter int    PC_WIDTH  = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [PC_WIDTH-1:0] pc_plus_4_in,
  output logic                iREN,
  output logic [PC_WIDTH-1:0] iaddr,
  input  logic                ihit,
  input  word_t               iload,
  input  logic                stall,
  input  logic                flush,
  input  logic                halt_in,
  output logic                pc_en,
  output logic                ifid_valid,
  output word_t               ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc4
);

  fetch_state_t        state, next_state;
  logic                iren_c, pc_en_c;
  logic                ifid_load, ifid_bubble;
  word_t               ld_instr;
  logic [PC_WIDTH-1:0] ld_pc4;

`ifdef FETCH_SKID_BUFFER_EN
  // The buffer is full exactly while in BUFFERED, so no separate valid bit.
  logic                buf_capture, from_buf;
  word_t               buf_instr;
  logic [PC_WIDTH-1:0] buf_pc4;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      buf_instr <= NOP_INSTR;
      buf_pc4   <= '0;
    end else if (buf_capture) begin
      buf_instr <= iload;
      buf_pc4   <= pc_plus_4_in;
    end
  end
`endif

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (halt_in)             next_state = HALTED;
        else if (flush)          next_state = FETCH;
`ifdef FETCH_SKID_BUFFER_EN
        else if (stall && ihit)  next_state = BUFFERED;
`endif
        else                     next_state = FETCH;
      end
      BUFFERED: begin
        if (halt_in)             next_state = HALTED;
        else if (flush || !stall) next_state = FETCH;
        else                     next_state = BUFFERED;
      end
      HALTED:  next_state = HALTED;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    iren_c      = 1'b0;
    pc_en_c     = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
`ifdef FETCH_SKID_BUFFER_EN
    buf_capture = 1'b0;
    from_buf    = 1'b0;
`endif
    case (state)
      FETCH: begin
        iren_c = 1'b1;
        if (halt_in) begin
          ifid_bubble = 1'b1;
        end else if (flush) begin
          pc_en_c     = 1'b1;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          // Without the buffer a word arriving now is dropped and the same PC re-fetched.
`ifdef FETCH_SKID_BUFFER_EN
          if (ihit) begin
            pc_en_c     = 1'b1;
            buf_capture = 1'b1;
          end
`endif
        end else if (ihit) begin
          pc_en_c   = 1'b1;
          ifid_load = 1'b1;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      BUFFERED: begin
        if (halt_in) begin
          ifid_bubble = 1'b1;
        end else if (flush) begin
          pc_en_c     = 1'b1;
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          ifid_load = 1'b1;
`ifdef FETCH_SKID_BUFFER_EN
          from_buf  = 1'b1;
`endif
        end
      end
      default: ifid_bubble = 1'b1;
    endcase
  end

  always_comb begin
    ld_instr = iload;
    ld_pc4   = pc_plus_4_in;
`ifdef FETCH_SKID_BUFFER_EN
    if (from_buf) begin
      ld_instr = buf_instr;
      ld_pc4   = buf_pc4;
    end
`endif
  end

  // Gated by nRST so no request or PC step is visible while reset is held.
  assign iREN  = iren_c & nRST;
  assign pc_en = pc_en_c & nRST;
  assign iaddr = pc_in;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR),
    .PC_WIDTH  (PC_WIDTH)
  ) u_if_id (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (ld_instr),
    .pc4_in   (ld_pc4),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4)
  );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter NOP_INSTR, 32'h00000000, instruction word loaded into IF/ID on bubble/flush/reset.
REQ-002 SHALL have parameter PC_WIDTH, 32, width of all address and PC-related ports.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc_in  input  32  current PC from program counter (fetch address).
REQ-006 SHALL have port pc_plus_4_in  input  32  PC+4 from program counter.
REQ-007 SHALL have port iREN  output  1  instruction memory read enable.
REQ-008 SHALL have port iaddr  output  32  instruction memory address.
REQ-009 SHALL have port ihit  input  1  instruction memory returns valid iload this cycle.
REQ-010 SHALL have port iload  input  32  instruction word from memory.
REQ-011 SHALL have port stall  input  1  hazard unit: hold IF/ID contents.
REQ-012 SHALL have port flush  input  1  taken branch/jump: squash fetched instruction, redirect PC.
REQ-013 SHALL have port halt_in  input  1  HALT decoded downstream; freeze fetch.
REQ-014 SHALL have port pc_en  output  1  advance/load program counter this cycle.
REQ-015 SHALL have ports ifid_valid (output 1), ifid_instr (output 32), ifid_pc4 (output 32): IF/ID register contents.

Function
REQ-016 SHALL implement states FETCH, BUFFERED, HALTED; priority per cycle: halt_in > flush > stall > ihit.
REQ-017 iaddr SHALL equal pc_in combinationally in all states; iREN SHALL be 1 only in FETCH.
REQ-018 FETCH, ihit=1, stall=0, flush=0: SHALL load ifid_instr<=iload, ifid_pc4<=pc_plus_4_in, ifid_valid<=1 at that edge; pc_en=1 same cycle (latency one edge, ihit cycle to IF/ID).
REQ-019 FETCH, ihit=0, stall=0, flush=0: SHALL insert bubble (ifid_valid<=0, ifid_instr<=NOP_INSTR); pc_en=0.
REQ-020 stall=1 (no flush/halt): IF/ID SHALL hold all three fields unchanged.
REQ-021 flush=1 in FETCH or BUFFERED: pc_en=1 regardless of ihit; IF/ID SHALL load bubble; any buffered word discarded; next state FETCH.
REQ-022 flush=1 and stall=1 together: flush SHALL win (bubble, pc_en=1).
REQ-023 halt_in=1 in any state: next state HALTED, IF/ID bubble, pc_en=0; HALTED SHALL exit only via reset.
REQ-024 HALTED: iREN=0, pc_en=0, IF/ID holds bubble; ihit, stall, flush ignored.
REQ-025 ihit while iREN=0 SHALL be ignored.

Reset
REQ-026 nRST low SHALL asynchronously force state FETCH, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0, buffer invalid.
REQ-027 Reset mid-fetch SHALL discard the in-flight request; first iREN=1 in the cycle after nRST deasserts.

Configuration
REQ-028 Macro FETCH_SKID_BUFFER_EN SHALL compile in a one-entry skid buffer (instr + pc4).
REQ-029 With macro: FETCH, ihit=1, stall=1 SHALL capture iload/pc_plus_4_in into buffer, pc_en=1, go BUFFERED; BUFFERED with stall=0 SHALL move buffer into IF/ID (valid=1), pc_en=0, go FETCH; BUFFERED with stall=1 holds.
REQ-030 Without macro: BUFFERED state SHALL be unreachable; FETCH, ihit=1, stall=1 SHALL drop the word, pc_en=0, remain FETCH (same PC re-fetched).

Structure
REQ-031 word_t SHALL come from cpu_types_pkg; fetch_state_t enum (FETCH, BUFFERED, HALTED) SHALL be added to cpu_types_pkg.
REQ-032 IF/ID register SHALL be sub-module if_id_reg (load, bubble, hold controls); FSM and pc_en logic in fetch_stage.

Verification
REQ-033 Reset, pc_in=0x0, ihit=1 every cycle -> iREN=1 first cycle, ifid_instr=iload, ifid_pc4=0x4, valid=1 after one edge; pc_en=1 every cycle.
REQ-034 ihit low 3 cycles at pc_in=0x10 -> 3 bubbles (valid=0, instr=0x0), pc_en=0, iaddr stays 0x10.
REQ-035 IF/ID holds 0x8C220004; stall=1 two cycles, ihit=1 -> IF/ID unchanged; with macro pc_en=1 once then BUFFERED, word appears after stall drops; without macro pc_en=0 both cycles.
REQ-036 flush=1 with stall=1 and ihit=0 -> pc_en=1, next IF/ID valid=0, instr=NOP_INSTR, state FETCH, buffer empty.
REQ-037 halt_in=1 -> next cycle iREN=0, pc_en=0 indefinitely despite ihit/flush; nRST pulse -> FETCH, iREN=1.
REQ-038 nRST asserted mid-BUFFERED -> outputs reset immediately without clock edge; buffered word never reaches IF/ID.
